// File: rtl/down_count_timer_arb.sv
// down_count_timer_arb
//   Shares one down-count timer between two requesters. An idle timer is
//   granted round-robin. The timer loads the owner's start value and counts
//   down to zero, pulses done to the owner for one cycle, then releases.
//   Every output comes from a register, so there is no combinational path
//   from req to grant.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   req0, req1    requests, held until done or dropped to abort
//   load0, load1  start values, sampled only on the grant edge
//   grant0/1      timer owner (one-hot or zero)
//   done0/1       one-cycle completion pulse to the owner
//   count         current timer value
//   busy          timer in use
module down_count_timer_arb #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] load0,
   input  logic             req1,
   input  logic [WIDTH-1:0] load1,
   output logic             grant0,
   output logic             grant1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] count,
   output logic             busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [WIDTH-1:0] CountZero = '0;
   localparam logic [WIDTH-1:0] CountOne  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             grant0_q, grant0_d;
   logic             grant1_q, grant1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   // 1: requester 1 wins a tie; 0: requester 0 wins a tie.
   logic             prio1_q, prio1_d;
   logic             owner_req;

   // Only the owner's request matters while the timer runs.
   assign owner_req = grant0_q ? req0 : req1;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      grant0_d = grant0_q;
      grant1_d = grant1_q;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      prio1_d  = prio1_q;

      case (state_q)
         StIdle: begin
            if (req0 && (!req1 || !prio1_q)) begin
               state_d  = StRun;
               grant0_d = 1'b1;
               count_d  = load0;
               prio1_d  = 1'b1;
            end else if (req1) begin
               state_d  = StRun;
               grant1_d = 1'b1;
               count_d  = load1;
               prio1_d  = 1'b0;
            end
         end

         StRun: begin
            if (!owner_req) begin
               // Abort: release silently, no done pulse.
               state_d  = StIdle;
               grant0_d = 1'b0;
               grant1_d = 1'b0;
               count_d  = CountZero;
            end else if (count_q != CountZero) begin
               count_d = count_q - CountOne;
            end else begin
               state_d = StDone;
               done0_d = grant0_q;
               done1_d = grant1_q;
            end
         end

         StDone: begin
            state_d  = StIdle;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            count_d  = CountZero;
         end

         default: begin
            state_d  = StIdle;
            grant0_d = 1'b0;
            grant1_d = 1'b0;
            count_d  = CountZero;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= CountZero;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         prio1_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         prio1_q  <= prio1_d;
      end
   end

   assign grant0 = grant0_q;
   assign grant1 = grant1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign count  = count_q;
   assign busy   = grant0_q | grant1_q;

endmodule

// File: doc/down_count_timer_arb.md
Name: down_count_timer_arb

Overview:
Arbiter and sequencer that shares one down-count timer between two requesters. A requester raises req with a load value. The block grants the timer round-robin, counts down from the load value to zero, pulses done to the owner, then releases the timer. It sits between client control logic and the shared counter datapath and owns all sequencing of that counter.

Parameters:
WIDTH, 3, counter width in bits; load values and count are WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 wants the timer; held high until done0 or abort
load0  input  WIDTH  requester 0 start value, sampled only on the grant edge
req1  input  1  requester 1 wants the timer
load1  input  WIDTH  requester 1 start value, sampled only on the grant edge
grant0  output  1  timer owned by requester 0
grant1  output  1  timer owned by requester 1
done0  output  1  one-cycle pulse: requester 0 countdown finished
done1  output  1  one-cycle pulse: requester 1 countdown finished
count  output  WIDTH  current timer value (registered)
busy  output  1  timer in use (state != IDLE)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; count=0; grant0=grant1=done0=done1=busy=0.
  - Round-robin pointer set so req0 has priority.
  - Reset overrides every other event, including mid-RUN or mid-DONE. No done pulse is generated.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state. No combinational path from req to grant.
- IDLE:
  - No req: stay IDLE, count holds 0.
  - Exactly one req high: next edge → RUN, grant for that requester =1, count=its load value.
  - Both req high: the pointer selects the winner. After reset the pointer favours req0. After each grant the pointer favours the other requester.
  - Pointer updates only on a grant edge.
- RUN:
  - Granted req high and count!=0: count decrements by 1 per cycle.
  - Granted req high and count==0: next edge → DONE, done pulse for owner =1, count stays 0.
  - Granted req low (abort): next edge → IDLE, grant=0, count=0, no done pulse.
  - The non-granted req is ignored.
- DONE:
  - Lasts exactly one cycle with grant still high. Next edge → IDLE, grant=0, done=0.
  - Owner may drop req in the DONE cycle or later. If owner req is still high in IDLE, it re-arbitrates like a fresh request.
- Latency:
  - Grant appears 1 cycle after req is sampled in IDLE.
  - With load value L, done pulses L+1 cycles after the grant edge.
  - Grant stays high for L+2 cycles in total.
  - Minimum one IDLE cycle between consecutive grants.
- Load 0: RUN for one cycle at count=0, then DONE.
- Load at maximum (2^WIDTH-1): counts to 0 with no wrap. Count never decrements below 0 and never wraps.
- Invariants:
  - grant0 and grant1 are never high together.
  - done0 and done1 are never high together.
  - done implies the matching grant is high.
  - busy = grant0 | grant1.

Test Plan:
- Reset: rst=1 for 2 cycles with req0=req1=1 → all outputs 0, state IDLE. After release, req0 wins first grant.
- Single request: req0=1, load0=5 at cycle 0 → grant0=1 at edge 1. Count 5,4,3,2,1,0 on edges 1–6. done0=1 at edge 7 only. grant0=0 at edge 8.
- Contention fairness: req0=req1=1 continuously, load0=2, load1=1 → grants alternate 0,1,0,1. Each grant separated by one IDLE cycle. done0/done1 never overlap.
- Abort: req1 alone, load1=6; drop req1 when count=3 → next edge grant1=0, count=0, busy=0, done1 never asserted. Pointer still favours req0 next.
- Boundaries: load0=0 → done0 at edge 2. load0=7 (WIDTH=3) → count 7..0, done0 at edge 9, no wrap to 7.
- Reset mid-operation: rst=1 while count=4 in RUN for requester 0 → next edge all outputs 0, IDLE. No done0 pulse. Simultaneous requests after reset grant req0 first.
